fe_fifo_packer: RTL and testbench
=================================

Name: fe_fifo_packer

Overview:
- Downstream neighbour of the front-end capture stage. Takes its per-event write strobe, 2-bit command, timestamp and data byte, and packs them into fixed-width FIFO words.
- Absorbs short FIFO backpressure through a 2-entry staging queue.
- On overflow, stops accepting events and drives the sticky overflow-blocked flag that the capture stage uses to gate further capture.
- Sits between the capture stage and the front-end FIFO write port, entirely in the fe_clk domain.

Parameters:
- pTIMESTAMP_FULL_WIDTH, 16, width of the timestamp carried by TIME words.
- pTIMESTAMP_SHORT_WIDTH, 3, width of the inline timestamp carried by data words.
- pFIFO_WIDTH, 18, FIFO word width; must equal 2 + pTIMESTAMP_FULL_WIDTH.
- pDROP_CNT_WIDTH, 16, width of the dropped-event counter.

Ports:
- fe_clk, input, 1, front-end clock; the only clock.
- reset_n, input, 1, reset, synchronous, active-low.
- I_fifo_wr, input, 1, event strobe from the capture stage.
- I_fifo_command, input, 2, event command.
- I_fifo_time, input, pTIMESTAMP_FULL_WIDTH, event timestamp.
- I_fifo_data, input, 8, captured data byte.
- I_flush, input, 1, FIFO flush / re-arm, already in fe_clk.
- I_fifo_full, input, 1, FIFO full.
- O_fifo_wr, output, 1, FIFO write enable.
- O_fifo_din, output, pFIFO_WIDTH, FIFO write word.
- O_fifo_overflow_blocked, output, 1, sticky overflow flag.
- O_ts_trunc, output, 1, sticky flag: a data word's timestamp did not fit the short field.
- O_drop_count, output, pDROP_CNT_WIDTH, saturating count of dropped events.

Behaviour:
- Word format, TIME command (`FE_FIFO_CMD_TIME`): {cmd[1:0], time[15:0]}.
- Word format, other commands: {cmd[1:0], 5'b0, time[2:0], data[7:0]}.
- If a data word's time > 2^pTIMESTAMP_SHORT_WIDTH-1, the field is truncated to the low bits and O_ts_trunc sets.
- Packing is combinational on the inputs and registered into the queue on acceptance.
- Queue: 2 entries, head/tail pointers, 2-bit count 0..2.
- Pop condition: count != 0 && !I_fifo_full.
- O_fifo_wr = pop condition, combinational from registered count plus I_fifo_full. O_fifo_din = head entry, registered storage.
- Latency: with the queue empty and FIFO not full, an event strobed in cycle N is written in cycle N+1. No bypass path.
- Accept condition: I_fifo_wr && !O_fifo_overflow_blocked && (count < 2 || pop).
- Push and pop in the same cycle at count==2: push accepted, count stays 2.
- Push and pop in the same cycle at count==1: count stays 1, new entry becomes head next cycle.
- Drop condition: I_fifo_wr && (blocked || (count==2 && !pop)). On drop, O_drop_count increments, saturating at all-ones.
- The first drop sets O_fifo_overflow_blocked in the next cycle. The blocked flag stays set until I_flush.
- While blocked, every further input strobe is dropped, so no partial timestamp/data sequences reach the FIFO. The queue keeps draining normally.
- I_flush has top priority in the cycle it is high:
  - count <= 0;
  - O_fifo_overflow_blocked, O_ts_trunc and O_drop_count clear;
  - O_fifo_wr forced 0;
  - a same-cycle I_fifo_wr is discarded and not counted.
- Reset (reset_n==0 at a fe_clk edge):
  - count 0, pointers 0, queue storage 0;
  - O_fifo_wr 0, O_fifo_din 0;
  - blocked 0, O_ts_trunc 0, O_drop_count 0.
- Reset mid-operation discards all queued words, with no partial write.
- O_fifo_wr must never assert while I_fifo_full is high.

Decomposition:
- Shared defines file, already used by the front end: FE_FIFO_CMD_* codes, word field offsets (CMD_LSB=16, TS_SHORT_LSB=8, DATA_LSB=0), width consistency check.
- One natural sub-module: fe_skid_queue2, a generic 2-entry FIFO with push, pop, count, head and flush. The packing, drop and sticky-flag logic stays in the top module.

Test Plan:
- Single data event, time=5, cmd=2'b00, data=0xA5, FIFO not full → next cycle O_fifo_wr=1, O_fifo_din=18'h005A5; queue empty afterwards.
- TIME event, cmd=`FE_FIFO_CMD_TIME`, time=16'h1234, followed next cycle by data event time=0, data=0x3C → two consecutive writes: {TIME,16'h1234}, then {cmd,5'b0,3'd0,8'h3C}.
- I_fifo_full held for 4 cycles while 3 events strobe back-to-back:
  - first 2 events queued, third dropped, O_drop_count=1, blocked=1;
  - on full release, exactly 2 writes in order;
  - a further strobe is dropped, O_drop_count=2.
- Blocked state, then I_flush=1 for one cycle with a simultaneous strobe → count=0, flags 0, drop_count 0. Next strobe is written 1 cycle later.
- Data event with time=9 → low bits 3'd1 in the word, O_ts_trunc=1 until flush.
- reset_n=0 asserted with 2 queued entries and full high → next cycle all outputs 0. After release with full low, no spurious O_fifo_wr.

Source files
------------

// File: rtl/fe_fifo_packer_pkg.sv
// Shared front-end FIFO definitions: command codes, word field offsets and
// the word-width consistency rule.
package fe_fifo_packer_pkg;

    typedef enum logic [1:0] {
        FE_FIFO_CMD_DATA = 2'b00,
        FE_FIFO_CMD_MARK = 2'b01,
        FE_FIFO_CMD_TRIG = 2'b10,
        FE_FIFO_CMD_TIME = 2'b11
    } fe_fifo_cmd_e;

    localparam int unsigned CMD_LSB      = 16;
    localparam int unsigned TS_SHORT_LSB = 8;
    localparam int unsigned DATA_LSB     = 0;

    function automatic bit fifo_width_ok(input int unsigned ts_full_width,
                                         input int unsigned fifo_width);
        return fifo_width == ts_full_width + 2;
    endfunction

endpackage

// File: rtl/fe_skid_queue2.sv
// Generic 2-entry FIFO with head/tail pointers. The caller guarantees push
// only when there is room (count < 2, or a same-cycle pop).
module fe_skid_queue2 #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             head_ptr;
    logic             tail_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count    <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else if (flush) begin
            count    <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
        end else begin
            // When full, tail aliases head, so a push+pop overwrites the slot being popped.
            if (push) begin
                mem[tail_ptr] <= din;
                tail_ptr      <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[head_ptr];

endmodule

// File: rtl/fe_fifo_packer.sv
// Packs capture-stage events into FIFO words, absorbs short backpressure in a
// 2-entry queue, and blocks further events after the first drop until flush.
module fe_fifo_packer
    import fe_fifo_packer_pkg::*;
#(
    parameter int unsigned pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int unsigned pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int unsigned pFIFO_WIDTH            = 18,
    parameter int unsigned pDROP_CNT_WIDTH        = 16
) (
    input  logic                             fe_clk,
    input  logic                             reset_n,
    input  logic                             I_fifo_wr,
    input  logic [1:0]                       I_fifo_command,
    input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_fifo_time,
    input  logic [7:0]                       I_fifo_data,
    input  logic                             I_flush,
    input  logic                             I_fifo_full,
    output logic                             O_fifo_wr,
    output logic [pFIFO_WIDTH-1:0]           O_fifo_din,
    output logic                             O_fifo_overflow_blocked,
    output logic                             O_ts_trunc,
    output logic [pDROP_CNT_WIDTH-1:0]       O_drop_count
);

    if (!fifo_width_ok(pTIMESTAMP_FULL_WIDTH, pFIFO_WIDTH)) begin : g_width_check
        $error("fe_fifo_packer: pFIFO_WIDTH must equal 2 + pTIMESTAMP_FULL_WIDTH");
    end

    logic [pFIFO_WIDTH-1:0] word;
    logic                   is_time;
    logic                   ts_overflow;
    logic [1:0]             count;
    logic                   pop;
    logic                   accept;
    logic                   drop;

    assign is_time     = (I_fifo_command == FE_FIFO_CMD_TIME);
    assign ts_overflow = |I_fifo_time[pTIMESTAMP_FULL_WIDTH-1:pTIMESTAMP_SHORT_WIDTH];

    always_comb begin
        word = '0;
        if (is_time) begin
            word = {I_fifo_command, I_fifo_time};
        end else begin
            word[pFIFO_WIDTH-1 -: 2]                        = I_fifo_command;
            word[TS_SHORT_LSB +: pTIMESTAMP_SHORT_WIDTH]    = I_fifo_time[pTIMESTAMP_SHORT_WIDTH-1:0];
            word[DATA_LSB +: 8]                             = I_fifo_data;
        end
    end

    // Flush and reset both suppress the write so no word leaks out while the queue is discarded.
    assign pop    = reset_n && !I_flush && (count != 2'd0) && !I_fifo_full;
    assign accept = !I_flush && I_fifo_wr && !O_fifo_overflow_blocked && ((count < 2'd2) || pop);
    assign drop   = !I_flush && I_fifo_wr && (O_fifo_overflow_blocked || ((count == 2'd2) && !pop));

    fe_skid_queue2 #(
        .WIDTH (pFIFO_WIDTH)
    ) u_queue (
        .clk     (fe_clk),
        .reset_n (reset_n),
        .flush   (I_flush),
        .push    (accept),
        .pop     (pop),
        .din     (word),
        .count   (count),
        .head    (O_fifo_din)
    );

    assign O_fifo_wr = pop;

    always_ff @(posedge fe_clk) begin
        if (!reset_n || I_flush) begin
            O_fifo_overflow_blocked <= 1'b0;
            O_ts_trunc              <= 1'b0;
            O_drop_count            <= '0;
        end else begin
            if (drop) begin
                O_fifo_overflow_blocked <= 1'b1;
                if (O_drop_count != '1) begin
                    O_drop_count <= O_drop_count + 1'b1;
                end
            end
            if (accept && !is_time && ts_overflow) begin
                O_ts_trunc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fe_fifo_packer.sv
// Directed bench for fe_fifo_packer: packing, latency, backpressure, drop/block,
// flush, timestamp truncation and mid-operation reset.
module tb_fe_fifo_packer;

    logic        fe_clk = 1'b0;
    logic        reset_n;
    logic        I_fifo_wr;
    logic [1:0]  I_fifo_command;
    logic [15:0] I_fifo_time;
    logic [7:0]  I_fifo_data;
    logic        I_flush;
    logic        I_fifo_full;
    logic        O_fifo_wr;
    logic [17:0] O_fifo_din;
    logic        O_fifo_overflow_blocked;
    logic        O_ts_trunc;
    logic [15:0] O_drop_count;

    int total = 0;
    int bad   = 0;

    always #5 fe_clk = ~fe_clk;

    fe_fifo_packer #(
        .pTIMESTAMP_FULL_WIDTH  (16),
        .pTIMESTAMP_SHORT_WIDTH (3),
        .pFIFO_WIDTH            (18),
        .pDROP_CNT_WIDTH        (16)
    ) dut (
        .fe_clk                  (fe_clk),
        .reset_n                 (reset_n),
        .I_fifo_wr               (I_fifo_wr),
        .I_fifo_command          (I_fifo_command),
        .I_fifo_time             (I_fifo_time),
        .I_fifo_data             (I_fifo_data),
        .I_flush                 (I_flush),
        .I_fifo_full             (I_fifo_full),
        .O_fifo_wr               (O_fifo_wr),
        .O_fifo_din              (O_fifo_din),
        .O_fifo_overflow_blocked (O_fifo_overflow_blocked),
        .O_ts_trunc              (O_ts_trunc),
        .O_drop_count            (O_drop_count)
    );

    task automatic cyc();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic ev(input logic [1:0] cmd, input logic [15:0] t, input logic [7:0] d);
        I_fifo_wr      = 1'b1;
        I_fifo_command = cmd;
        I_fifo_time    = t;
        I_fifo_data    = d;
    endtask

    task automatic idle();
        I_fifo_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; I_fifo_wr = 1'b0; I_fifo_command = 2'b00; I_fifo_time = '0;
        I_fifo_data = '0; I_flush = 1'b0; I_fifo_full = 1'b0;
        cyc(); cyc();
        #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", O_fifo_wr); end
        total++; if (O_fifo_din !== 18'h0) begin bad++; $display("FAIL reset_din got=%h exp=0", O_fifo_din); end
        total++; if (O_fifo_overflow_blocked !== 1'b0) begin bad++; $display("FAIL reset_blocked got=%b exp=0", O_fifo_overflow_blocked); end
        total++; if (O_ts_trunc !== 1'b0) begin bad++; $display("FAIL reset_trunc got=%b exp=0", O_ts_trunc); end
        total++; if (O_drop_count !== 16'h0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", O_drop_count); end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        I_fifo_full = 1'b0;
        ev(2'b00, 16'd5, 8'hA5);
        cyc(); idle(); #1;
        total++; if (O_fifo_wr !== 1'b1) begin bad++; $display("FAIL single_wr got=%b exp=1", O_fifo_wr); end
        total++; if (O_fifo_din !== 18'h005A5) begin bad++; $display("FAIL single_din got=%h exp=005a5", O_fifo_din); end
        cyc(); #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", O_fifo_wr); end
    endtask

    task automatic test_time_pair();
        ev(2'b11, 16'h1234, 8'h00);
        cyc(); ev(2'b00, 16'd0, 8'h3C); #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h31234) begin bad++; $display("FAIL time_word wr=%b got=%h exp=31234", O_fifo_wr, O_fifo_din); end
        cyc(); idle(); #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h0003C) begin bad++; $display("FAIL time_data wr=%b got=%h exp=0003c", O_fifo_wr, O_fifo_din); end
        cyc(); #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL time_empty got=%b exp=0", O_fifo_wr); end
    endtask

    task automatic test_back_to_back();
        I_fifo_full = 1'b1;
        ev(2'b00, 16'd1, 8'h01); cyc();
        ev(2'b00, 16'd2, 8'h02); cyc();
        I_fifo_full = 1'b0;
        ev(2'b01, 16'd3, 8'h03); #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h00101) begin bad++; $display("FAIL b2b_first wr=%b got=%h exp=00101", O_fifo_wr, O_fifo_din); end
        cyc(); idle(); #1;
        total++; if (O_fifo_din !== 18'h00202 || O_drop_count !== 16'd0 || O_fifo_overflow_blocked !== 1'b0) begin
            bad++; $display("FAIL b2b_second got=%h drop=%0d blk=%b exp=00202/0/0", O_fifo_din, O_drop_count, O_fifo_overflow_blocked);
        end
        cyc(); #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h10303) begin bad++; $display("FAIL b2b_third wr=%b got=%h exp=10303", O_fifo_wr, O_fifo_din); end
        cyc(); #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", O_fifo_wr); end
    endtask

    task automatic test_overflow();
        I_fifo_full = 1'b1;
        ev(2'b00, 16'd1, 8'h11); cyc();
        ev(2'b00, 16'd2, 8'h22); cyc();
        ev(2'b00, 16'd3, 8'h33); cyc();
        idle(); #1;
        total++; if (O_drop_count !== 16'd1 || O_fifo_overflow_blocked !== 1'b1) begin
            bad++; $display("FAIL ovf_drop drop=%0d blk=%b exp=1/1", O_drop_count, O_fifo_overflow_blocked);
        end
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL ovf_full_wr got=%b exp=0", O_fifo_wr); end
        cyc();
        I_fifo_full = 1'b0; #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h00111) begin bad++; $display("FAIL ovf_w1 wr=%b got=%h exp=00111", O_fifo_wr, O_fifo_din); end
        cyc(); #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h00222) begin bad++; $display("FAIL ovf_w2 wr=%b got=%h exp=00222", O_fifo_wr, O_fifo_din); end
        ev(2'b00, 16'd4, 8'h44); cyc(); idle(); #1;
        total++; if (O_fifo_wr !== 1'b0 || O_drop_count !== 16'd2 || O_fifo_overflow_blocked !== 1'b1) begin
            bad++; $display("FAIL ovf_blocked wr=%b drop=%0d blk=%b exp=0/2/1", O_fifo_wr, O_drop_count, O_fifo_overflow_blocked);
        end
    endtask

    task automatic test_flush();
        I_flush = 1'b1; ev(2'b00, 16'd6, 8'h66); cyc();
        I_flush = 1'b0; idle(); #1;
        total++; if (O_fifo_overflow_blocked !== 1'b0 || O_drop_count !== 16'd0 || O_ts_trunc !== 1'b0 || O_fifo_wr !== 1'b0) begin
            bad++; $display("FAIL flush_clear blk=%b drop=%0d trunc=%b wr=%b exp=0/0/0/0", O_fifo_overflow_blocked, O_drop_count, O_ts_trunc, O_fifo_wr);
        end
        ev(2'b00, 16'd7, 8'h77); cyc(); idle(); #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h00777) begin bad++; $display("FAIL flush_next wr=%b got=%h exp=00777", O_fifo_wr, O_fifo_din); end
        cyc();
        I_fifo_full = 1'b1; ev(2'b00, 16'd1, 8'h55); cyc();
        idle(); I_fifo_full = 1'b0; I_flush = 1'b1; #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL flush_force_wr got=%b exp=0", O_fifo_wr); end
        cyc(); I_flush = 1'b0; #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL flush_emptied got=%b exp=0", O_fifo_wr); end
    endtask

    task automatic test_trunc();
        ev(2'b00, 16'd9, 8'h5A); cyc(); idle(); #1;
        total++; if (O_fifo_wr !== 1'b1 || O_fifo_din !== 18'h0015A) begin bad++; $display("FAIL trunc_word wr=%b got=%h exp=0015a", O_fifo_wr, O_fifo_din); end
        total++; if (O_ts_trunc !== 1'b1) begin bad++; $display("FAIL trunc_flag got=%b exp=1", O_ts_trunc); end
        cyc(); cyc(); #1;
        total++; if (O_ts_trunc !== 1'b1) begin bad++; $display("FAIL trunc_sticky got=%b exp=1", O_ts_trunc); end
        I_flush = 1'b1; cyc(); I_flush = 1'b0; #1;
        total++; if (O_ts_trunc !== 1'b0) begin bad++; $display("FAIL trunc_flush got=%b exp=0", O_ts_trunc); end
        ev(2'b11, 16'hFFFF, 8'h00); cyc(); idle(); #1;
        total++; if (O_ts_trunc !== 1'b0 || O_fifo_din !== 18'h3FFFF) begin bad++; $display("FAIL trunc_time trunc=%b got=%h exp=0/3ffff", O_ts_trunc, O_fifo_din); end
        cyc();
    endtask

    task automatic test_reset_mid();
        I_fifo_full = 1'b1;
        ev(2'b00, 16'd1, 8'hAA); cyc();
        ev(2'b00, 16'd2, 8'hBB); cyc();
        idle(); reset_n = 1'b0; cyc(); #1;
        total++; if (O_fifo_wr !== 1'b0 || O_fifo_din !== 18'h0 || O_fifo_overflow_blocked !== 1'b0 ||
                     O_ts_trunc !== 1'b0 || O_drop_count !== 16'd0) begin
            bad++; $display("FAIL midreset_outs wr=%b din=%h blk=%b trunc=%b drop=%0d exp=all0",
                            O_fifo_wr, O_fifo_din, O_fifo_overflow_blocked, O_ts_trunc, O_drop_count);
        end
        reset_n = 1'b1; I_fifo_full = 1'b0; #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL midreset_release got=%b exp=0", O_fifo_wr); end
        cyc(); #1;
        total++; if (O_fifo_wr !== 1'b0) begin bad++; $display("FAIL midreset_after got=%b exp=0", O_fifo_wr); end
    endtask

    always @(negedge fe_clk) begin
        if (reset_n === 1'b1 && I_fifo_full === 1'b1 && O_fifo_wr === 1'b1) begin
            bad++; total++;
            $display("FAIL wr_while_full got=1 exp=0");
        end
    end

    initial begin
        test_reset();
        test_single();
        test_time_pair();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_trunc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
